// File: rtl/csa_sub_10bit_pipe.sv
// csa_sub_10bit_pipe: two-stage pipelined 10-bit carry-select subtractor.
// Ports: clk, rst_n (sync, active-low), i_valid/i_ready/i_sub_term1/i_sub_term2 in,
// o_valid/o_ready/diff/bout out, overflow out only when SUB_OVF_EN is defined.
module csa_sub_10bit_pipe #(
  parameter int STAGE_SPLIT = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  output logic       i_ready,
  input  logic [9:0] i_sub_term1,
  input  logic [9:0] i_sub_term2,
  output logic       o_valid,
  input  logic       o_ready,
  output logic [9:0] diff,
  output logic       bout
`ifdef SUB_OVF_EN
  ,
  output logic       overflow
`endif
);

  localparam int S    = STAGE_SPLIT;
  localparam int HW   = 10 - S;
  localparam int NBLK = (S - 1) / 2;

  typedef struct packed {
    logic [S-1:0]  lo;
    logic          c;
    logic [HW-1:0] a_hi;
    logic [HW-1:0] b_hi;
  } s1_t;

  // ---------------- handshake ----------------
  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv  = !o_valid || o_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign i_ready = s1_adv;

  // ---------------- stage 1: low bits ----------------
  // a + ~b + 1: the +1 is the carry-in of the ripple block.
  logic [S-1:0] a_lo;
  logic [S-1:0] nb_lo;
  logic [S-1:0] lo_diff;
  logic         p0;
  logic         p1;
  logic         c1;
  logic         c2;
  logic         lo_cout;

  assign a_lo  = i_sub_term1[S-1:0];
  assign nb_lo = ~i_sub_term2[S-1:0];

  assign p0         = a_lo[0] ^ nb_lo[0];
  assign lo_diff[0] = ~p0;
  assign c1         = (a_lo[0] & nb_lo[0]) | p0;
  assign p1         = a_lo[1] ^ nb_lo[1];
  assign lo_diff[1] = p1 ^ c1;
  assign c2         = (a_lo[1] & nb_lo[1]) | (p1 & c1);

  // 2-bit carry-select blocks; the last one is 1 bit wide for odd splits.
  for (genvar g = 0; g < NBLK; g++) begin : g_csel
    localparam int LO = 2 + 2 * g;
    localparam int W  = (S - LO >= 2) ? 2 : 1;

    logic         cin;
    logic         cout;
    logic [W:0]   sum0;
    logic [W:0]   sum1;

    if (g == 0) begin : g_first
      assign cin = c2;
    end else begin : g_next
      assign cin = g_csel[g-1].cout;
    end

    assign sum0 = {1'b0, a_lo[LO+W-1:LO]}
                + {1'b0, nb_lo[LO+W-1:LO]};
    assign sum1 = {1'b0, a_lo[LO+W-1:LO]}
                + {1'b0, nb_lo[LO+W-1:LO]}
                + (W+1)'(1);

    assign lo_diff[LO+W-1:LO] = cin ? sum1[W-1:0]
                                    : sum0[W-1:0];
    assign cout = cin ? sum1[W] : sum0[W];
  end

  if (NBLK == 0) begin : g_lo_rip
    assign lo_cout = c2;
  end else begin : g_lo_cs
    assign lo_cout = g_csel[NBLK-1].cout;
  end

  s1_t s1_d;
  s1_t s1_q;

  always_comb begin
    s1_d      = '0;
    s1_d.lo   = lo_diff;
    s1_d.c    = lo_cout;
    s1_d.a_hi = i_sub_term1[9:S];
    s1_d.b_hi = i_sub_term2[9:S];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // ---------------- stage 2: high bits ----------------
  logic [HW:0] hi_sum0;
  logic [HW:0] hi_sum1;
  logic [HW:0] hi_sel;
  logic [9:0]  diff_d;
  logic        bout_d;

  assign hi_sum0 = {1'b0, s1_q.a_hi}
                 + {1'b0, ~s1_q.b_hi};
  assign hi_sum1 = {1'b0, s1_q.a_hi}
                 + {1'b0, ~s1_q.b_hi}
                 + (HW+1)'(1);
  assign hi_sel  = s1_q.c ? hi_sum1 : hi_sum0;
  assign diff_d  = {hi_sel[HW-1:0], s1_q.lo};
  // Carry out of bit 9 set means no borrow.
  assign bout_d  = ~hi_sel[HW];

`ifdef SUB_OVF_EN
  logic ovf_d;

  assign ovf_d = (s1_q.a_hi[HW-1] != s1_q.b_hi[HW-1])
              && (hi_sel[HW-1] != s1_q.a_hi[HW-1]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
`ifdef SUB_OVF_EN
      overflow <= 1'b0;
`endif
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        diff     <= diff_d;
        bout     <= bout_d;
`ifdef SUB_OVF_EN
        overflow <= ovf_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_csa_sub_10bit_pipe.sv
// tb_csa_sub_10bit_pipe: scoreboard bench for csa_sub_10bit_pipe.
// Random + directed operands checked against an arithmetic reference model.
module tb_csa_sub_10bit_pipe;

  parameter int STAGE_SPLIT = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid;
  logic       i_ready;
  logic [9:0] i_sub_term1;
  logic [9:0] i_sub_term2;
  logic       o_valid;
  logic       o_ready;
  logic [9:0] diff;
  logic       bout;
`ifdef SUB_OVF_EN
  logic       overflow;
`endif

  always #5 clk = ~clk;

  csa_sub_10bit_pipe #(.STAGE_SPLIT(STAGE_SPLIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_sub_term1 (i_sub_term1),
    .i_sub_term2 (i_sub_term2),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .diff        (diff),
    .bout        (bout)
`ifdef SUB_OVF_EN
    ,
    .overflow    (overflow)
`endif
  );

  typedef struct packed {
    logic [9:0] d;
    logic       b;
    logic       v;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic res_t model(logic [9:0] a, logic [9:0] b);
    res_t r;
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    ua  = int'(a);
    ub  = int'(b);
    sa  = (ua >= 512) ? ua - 1024 : ua;
    sb  = (ub >= 512) ? ub - 1024 : ub;
    r.d = 10'((ua - ub + 1024) % 1024);
    r.b = (ua < ub);
    r.v = ((sa - sb) > 511) || ((sa - sb) < -512);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Input side: record every accepted pair.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && i_valid && i_ready)
      exp_q.push_back(model(i_sub_term1, i_sub_term2));
  end

  // Output side: compare every delivered result, and check held outputs.
  logic       prev_hold = 1'b0;
  logic [9:0] prev_d;
  logic       prev_b;

  always @(negedge clk) begin
    res_t e;
    if (rst_n !== 1'b1) begin
      exp_q.delete();
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(o_valid), 32'd1);
        check("hold_diff", 32'(diff), 32'(prev_d));
        check("hold_bout", 32'(bout), 32'(prev_b));
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h expected=none", diff);
        end else begin
          e = exp_q.pop_front();
          check("diff", 32'(diff), 32'(e.d));
          check("bout", 32'(bout), 32'(e.b));
`ifdef SUB_OVF_EN
          check("overflow", 32'(overflow), 32'(e.v));
`endif
        end
      end
    end
    prev_hold = (rst_n === 1'b1) && o_valid && !o_ready;
    prev_d    = diff;
    prev_b    = bout;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [9:0] a, logic [9:0] b);
    i_valid     = 1'b1;
    i_sub_term1 = a;
    i_sub_term2 = b;
    tick();
    i_valid = 1'b0;
  endtask

  function automatic logic [9:0] pick();
    case ($urandom % 8)
      0: return 10'h000;
      1: return 10'h3FF;
      2: return 10'h200;
      3: return 10'h1FF;
      default: return 10'($urandom);
    endcase
  endfunction

  initial begin
    int  sent;
    bit  saw_block;

    rst_n       = 1'b0;
    i_valid     = 1'b0;
    o_ready     = 1'b1;
    i_sub_term1 = '0;
    i_sub_term2 = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd1);

    // Latency: result visible two cycles after the input cycle.
    send(10'd5, 10'd3);
    check("lat_cycle1", 32'(o_valid), 32'd0);
    tick();
    check("lat_cycle2", 32'(o_valid), 32'd1);
    check("lat_diff", 32'(diff), 32'd2);
    tick();

    send(10'd0, 10'd1);
    send(10'h200, 10'h001);
    send(10'h1FF, 10'h3FF);
    send(10'h3FF, 10'h000);
    repeat (4) tick();

    // Back-to-back 8 pairs with the output stalled in cycles 3..6.
    sent      = 0;
    saw_block = 1'b0;
    for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
      o_ready     = !(cyc >= 3 && cyc <= 6);
      i_valid     = 1'b1;
      i_sub_term1 = 10'($urandom);
      i_sub_term2 = 10'($urandom);
      #1;
      if (!i_ready) saw_block = 1'b1;
      else sent++;
      tick();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    check("stall_block", 32'(saw_block), 32'd1);
    check("stall_sent", 32'(sent), 32'd8);
    repeat (5) tick();
    check("stall_drain", 32'(exp_q.size()), 32'd0);

    // Randomised traffic with random backpressure.
    for (int n = 0; n < 4000; n++) begin
      i_valid     = ($urandom % 4) != 0;
      o_ready     = ($urandom % 4) != 0;
      i_sub_term1 = pick();
      i_sub_term2 = pick();
      tick();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (5) tick();
    check("rand_drain", 32'(exp_q.size()), 32'd0);

    // Fill both stages, then reset mid-flight.
    o_ready = 1'b0;
    i_valid = 1'b1;
    repeat (3) begin
      i_sub_term1 = 10'($urandom);
      i_sub_term2 = 10'($urandom);
      tick();
    end
    check("full_i_ready", 32'(i_ready), 32'd0);
    check("full_o_valid", 32'(o_valid), 32'd1);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_o_valid", 32'(o_valid), 32'd0);
    check("mrst_i_ready", 32'(i_ready), 32'd1);
    o_ready = 1'b1;
    repeat (4) begin
      tick();
      check("mrst_idle", 32'(o_valid), 32'd0);
    end

    send(10'h155, 10'h2AA);
    repeat (4) tick();
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
